// File: rtl/rs_station_param.sv
// Reservation station: buffers DEPTH micro-ops, wakes operands/NZCV from NUM_CDB broadcast ports, issues oldest ready entry.
// Latency: an entry allocated fully ready at edge t issues in cycle t+1; a CDB wakeup at edge t allows issue in cycle t+1.
// Backpressure: alloc_ready drops when all DEPTH entries are held; issue holds while issue_ready is low, and an older entry may overtake.
module rs_station_param #(
    parameter  int DEPTH     = 16,
    parameter  int NUM_CDB   = 2,
    parameter  int DATA_W    = 64,
    parameter  int ROB_IDX_W = 6,
    parameter  int OP_W      = 6,
    localparam int OCC_W     = $clog2(DEPTH + 1)
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          flush_in,
    // allocate side
    input  logic                          alloc_valid,
    output logic                          alloc_ready,
    input  logic [OP_W-1:0]               alloc_op,
    input  logic [ROB_IDX_W-1:0]          alloc_dst_rob,
    input  logic                          alloc_a_valid,
    input  logic [ROB_IDX_W-1:0]          alloc_a_rob,
    input  logic [DATA_W-1:0]             alloc_a_value,
    input  logic                          alloc_b_valid,
    input  logic [ROB_IDX_W-1:0]          alloc_b_rob,
    input  logic [DATA_W-1:0]             alloc_b_value,
    input  logic                          alloc_uses_nzcv,
    input  logic                          alloc_nzcv_valid,
    input  logic [ROB_IDX_W-1:0]          alloc_nzcv_rob,
    input  logic [3:0]                    alloc_nzcv,
    // result broadcast ports, port k in slice k
    input  logic [NUM_CDB-1:0]            cdb_valid,
    input  logic [NUM_CDB*ROB_IDX_W-1:0]  cdb_rob,
    input  logic [NUM_CDB*DATA_W-1:0]     cdb_value,
    input  logic [NUM_CDB-1:0]            cdb_set_nzcv,
    input  logic [NUM_CDB*4-1:0]          cdb_nzcv,
    // issue side
    output logic                          issue_valid,
    input  logic                          issue_ready,
    output logic [OP_W-1:0]               issue_op,
    output logic [DATA_W-1:0]             issue_val_a,
    output logic [DATA_W-1:0]             issue_val_b,
    output logic [ROB_IDX_W-1:0]          issue_dst_rob,
    output logic [3:0]                    issue_nzcv,
    output logic [OCC_W-1:0]              occupancy
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int PORT_W = (NUM_CDB > 1) ? $clog2(NUM_CDB) : 1;

    typedef struct packed {
        logic [OP_W-1:0]      op;
        logic [ROB_IDX_W-1:0] dst_rob;
        logic                 a_rdy;
        logic [ROB_IDX_W-1:0] a_rob;
        logic [DATA_W-1:0]    a_val;
        logic                 b_rdy;
        logic [ROB_IDX_W-1:0] b_rob;
        logic [DATA_W-1:0]    b_val;
        logic                 uses_nzcv;
        logic                 f_rdy;
        logic [ROB_IDX_W-1:0] f_rob;
        logic [3:0]           f_val;
    } ent_t;

    // True when any port enabled in mask broadcasts tag
    function automatic logic cdb_match(input logic [ROB_IDX_W-1:0]         tag,
                                       input logic [NUM_CDB-1:0]           mask,
                                       input logic [NUM_CDB*ROB_IDX_W-1:0] robs);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_CDB; k++) begin
            if (mask[k] && (robs[k*ROB_IDX_W +: ROB_IDX_W] == tag)) hit = 1'b1;
        end
        return hit;
    endfunction

    // Lowest-numbered matching port; scanning downward lets the lowest overwrite last
    function automatic logic [PORT_W-1:0] cdb_pick(input logic [ROB_IDX_W-1:0]         tag,
                                                   input logic [NUM_CDB-1:0]           mask,
                                                   input logic [NUM_CDB*ROB_IDX_W-1:0] robs);
        logic [PORT_W-1:0] port;
        port = '0;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (mask[k] && (robs[k*ROB_IDX_W +: ROB_IDX_W] == tag)) port = PORT_W'(k);
        end
        return port;
    endfunction

    ent_t             ent_q   [DEPTH];
    ent_t             ent_d   [DEPTH];
    logic [DEPTH-1:0] age_q   [DEPTH];
    logic [DEPTH-1:0] age_d   [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;

    logic [DEPTH-1:0]   rdy_vec;
    logic [DEPTH-1:0]   sel_vec;
    logic [IDX_W-1:0]   free_idx;
    logic [NUM_CDB-1:0] nz_mask;
    logic               alloc_fire;
    logic               issue_fire;
    ent_t               alloc_ent;

    assign nz_mask     = cdb_valid & cdb_set_nzcv;
    assign alloc_ready = (occ_q < OCC_W'(DEPTH));
    assign alloc_fire  = alloc_valid && alloc_ready && !flush_in;
    assign issue_fire  = issue_valid && issue_ready;
    assign occupancy   = occ_q;

    // Per-entry readiness from registered state only
    always_comb begin
        rdy_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rdy_vec[i] = valid_q[i] && ent_q[i].a_rdy && ent_q[i].b_rdy &&
                         (!ent_q[i].uses_nzcv || ent_q[i].f_rdy);
        end
    end

    // Oldest-ready select: a ready entry wins if no ready entry is older than it
    always_comb begin
        sel_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sel_vec[i] = rdy_vec[i] && ((age_q[i] & rdy_vec) == '0);
        end
    end

    // Issue port mux; zeros whenever nothing is offered or a flush is in progress
    always_comb begin
        issue_valid   = 1'b0;
        issue_op      = '0;
        issue_val_a   = '0;
        issue_val_b   = '0;
        issue_dst_rob = '0;
        issue_nzcv    = '0;
        if (!flush_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (sel_vec[i]) begin
                    issue_valid   = 1'b1;
                    issue_op      = ent_q[i].op;
                    issue_val_a   = ent_q[i].a_val;
                    issue_val_b   = ent_q[i].b_val;
                    issue_dst_rob = ent_q[i].dst_rob;
                    issue_nzcv    = ent_q[i].uses_nzcv ? ent_q[i].f_val : 4'b0000;
                end
            end
        end
    end

    // Lowest-index free slot; a slot freed by this cycle's issue is not visible yet
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IDX_W'(i);
        end
    end

    // Incoming entry, with operands/flags captured from a same-cycle broadcast
    always_comb begin
        alloc_ent           = '0;
        alloc_ent.op        = alloc_op;
        alloc_ent.dst_rob   = alloc_dst_rob;
        alloc_ent.a_rob     = alloc_a_rob;
        alloc_ent.a_rdy     = alloc_a_valid;
        alloc_ent.a_val     = alloc_a_value;
        alloc_ent.b_rob     = alloc_b_rob;
        alloc_ent.b_rdy     = alloc_b_valid;
        alloc_ent.b_val     = alloc_b_value;
        alloc_ent.uses_nzcv = alloc_uses_nzcv;
        alloc_ent.f_rob     = alloc_nzcv_rob;
        alloc_ent.f_rdy     = alloc_nzcv_valid;
        alloc_ent.f_val     = alloc_nzcv;
        if (!alloc_a_valid && cdb_match(alloc_a_rob, cdb_valid, cdb_rob)) begin
            alloc_ent.a_rdy = 1'b1;
            alloc_ent.a_val = cdb_value[DATA_W*int'(cdb_pick(alloc_a_rob, cdb_valid, cdb_rob)) +: DATA_W];
        end
        if (!alloc_b_valid && cdb_match(alloc_b_rob, cdb_valid, cdb_rob)) begin
            alloc_ent.b_rdy = 1'b1;
            alloc_ent.b_val = cdb_value[DATA_W*int'(cdb_pick(alloc_b_rob, cdb_valid, cdb_rob)) +: DATA_W];
        end
        if (!alloc_nzcv_valid && cdb_match(alloc_nzcv_rob, nz_mask, cdb_rob)) begin
            alloc_ent.f_rdy = 1'b1;
            alloc_ent.f_val = cdb_nzcv[4*int'(cdb_pick(alloc_nzcv_rob, nz_mask, cdb_rob)) +: 4];
        end
    end

    // Next-state: wakeup, issue retire, allocation write, age update, flush
    always_comb begin
        ent_d   = ent_q;
        age_d   = age_q;
        valid_d = valid_q;
        occ_d   = occ_q + OCC_W'(alloc_fire) - OCC_W'(issue_fire);
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) begin
                if (!ent_q[i].a_rdy && cdb_match(ent_q[i].a_rob, cdb_valid, cdb_rob)) begin
                    ent_d[i].a_rdy = 1'b1;
                    ent_d[i].a_val = cdb_value[DATA_W*int'(cdb_pick(ent_q[i].a_rob, cdb_valid, cdb_rob)) +: DATA_W];
                end
                if (!ent_q[i].b_rdy && cdb_match(ent_q[i].b_rob, cdb_valid, cdb_rob)) begin
                    ent_d[i].b_rdy = 1'b1;
                    ent_d[i].b_val = cdb_value[DATA_W*int'(cdb_pick(ent_q[i].b_rob, cdb_valid, cdb_rob)) +: DATA_W];
                end
                if (!ent_q[i].f_rdy && cdb_match(ent_q[i].f_rob, nz_mask, cdb_rob)) begin
                    ent_d[i].f_rdy = 1'b1;
                    ent_d[i].f_val = cdb_nzcv[4*int'(cdb_pick(ent_q[i].f_rob, nz_mask, cdb_rob)) +: 4];
                end
            end
            if (issue_fire && sel_vec[i]) valid_d[i] = 1'b0;
        end
        if (alloc_fire) begin
            ent_d[free_idx]   = alloc_ent;
            valid_d[free_idx] = 1'b1;
            // Everything still held after this edge is older than the newcomer
            age_d[free_idx]   = valid_q & ~(issue_fire ? sel_vec : '0);
            // Nobody may consider the newcomer older than itself
            for (int r = 0; r < DEPTH; r++) begin
                age_d[r][free_idx] = 1'b0;
            end
        end
        if (flush_in) begin
            valid_d = '0;
            occ_d   = '0;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_q <= '0;
            occ_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
                age_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
                age_q[i] <= age_d[i];
            end
        end
    end

endmodule

// File: tb/tb_rs_station_param.sv
// Bench for rs_station_param: directed allocations/broadcasts, expected issues queued in a scoreboard.
// Latency: expectations are pushed when the stimulus that makes an issue inevitable is applied.
// Backpressure: issue_ready is driven per scenario; the monitor checks every issue handshake.
module tb_rs_station_param;

    localparam int DEPTH      = 8;
    localparam int NUM_CDB    = 2;
    localparam int DATA_W     = 64;
    localparam int ROB_IDX_W  = 6;
    localparam int OP_W       = 6;
    localparam int OCC_W      = $clog2(DEPTH + 1);
    localparam logic [OP_W-1:0] FU_OP_PLUS = 6'd1;

    logic                         clk_in, rst_in, flush_in;
    logic                         alloc_valid, alloc_ready;
    logic [OP_W-1:0]              alloc_op;
    logic [ROB_IDX_W-1:0]         alloc_dst_rob;
    logic                         alloc_a_valid, alloc_b_valid;
    logic [ROB_IDX_W-1:0]         alloc_a_rob, alloc_b_rob;
    logic [DATA_W-1:0]            alloc_a_value, alloc_b_value;
    logic                         alloc_uses_nzcv, alloc_nzcv_valid;
    logic [ROB_IDX_W-1:0]         alloc_nzcv_rob;
    logic [3:0]                   alloc_nzcv;
    logic [NUM_CDB-1:0]           cdb_valid, cdb_set_nzcv;
    logic [NUM_CDB*ROB_IDX_W-1:0] cdb_rob;
    logic [NUM_CDB*DATA_W-1:0]    cdb_value;
    logic [NUM_CDB*4-1:0]         cdb_nzcv;
    logic                         issue_valid, issue_ready;
    logic [OP_W-1:0]              issue_op;
    logic [DATA_W-1:0]            issue_val_a, issue_val_b;
    logic [ROB_IDX_W-1:0]         issue_dst_rob;
    logic [3:0]                   issue_nzcv;
    logic [OCC_W-1:0]             occupancy;

    rs_station_param #(
        .DEPTH(DEPTH), .NUM_CDB(NUM_CDB), .DATA_W(DATA_W),
        .ROB_IDX_W(ROB_IDX_W), .OP_W(OP_W)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_op(alloc_op), .alloc_dst_rob(alloc_dst_rob),
        .alloc_a_valid(alloc_a_valid), .alloc_a_rob(alloc_a_rob), .alloc_a_value(alloc_a_value),
        .alloc_b_valid(alloc_b_valid), .alloc_b_rob(alloc_b_rob), .alloc_b_value(alloc_b_value),
        .alloc_uses_nzcv(alloc_uses_nzcv), .alloc_nzcv_valid(alloc_nzcv_valid),
        .alloc_nzcv_rob(alloc_nzcv_rob), .alloc_nzcv(alloc_nzcv),
        .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_value(cdb_value),
        .cdb_set_nzcv(cdb_set_nzcv), .cdb_nzcv(cdb_nzcv),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_val_a(issue_val_a), .issue_val_b(issue_val_b),
        .issue_dst_rob(issue_dst_rob), .issue_nzcv(issue_nzcv),
        .occupancy(occupancy)
    );

    typedef struct {
        logic [OP_W-1:0]      op;
        logic [DATA_W-1:0]    a;
        logic [DATA_W-1:0]    b;
        logic [ROB_IDX_W-1:0] dst;
        logic [3:0]           nzcv;
    } exp_t;

    exp_t sb_q[$];
    int   vecs = 0;
    int   errs = 0;

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] a,
                            input logic [DATA_W-1:0] b, input logic [ROB_IDX_W-1:0] dst,
                            input logic [3:0] nz);
        exp_t e;
        e.op = op; e.a = a; e.b = b; e.dst = dst; e.nzcv = nz;
        sb_q.push_back(e);
    endtask

    // Monitor: every issue handshake must match the head of the scoreboard
    always @(negedge clk_in) begin
        if (!rst_in && issue_valid && issue_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_issue", {58'd0, issue_op}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("issue_op_dst_nzcv", {48'd0, issue_op, issue_dst_rob, issue_nzcv},
                      {48'd0, e.op, e.dst, e.nzcv});
                check("issue_val_a", issue_val_a, e.a);
                check("issue_val_b", issue_val_b, e.b);
            end
        end
    end

    task automatic set_alloc(input logic [OP_W-1:0] op, input logic [ROB_IDX_W-1:0] dst,
                             input logic av, input logic [ROB_IDX_W-1:0] arob, input logic [DATA_W-1:0] aval,
                             input logic bv, input logic [ROB_IDX_W-1:0] brob, input logic [DATA_W-1:0] bval,
                             input logic un, input logic nv, input logic [ROB_IDX_W-1:0] nrob,
                             input logic [3:0] nz);
        alloc_valid = 1'b1; alloc_op = op; alloc_dst_rob = dst;
        alloc_a_valid = av; alloc_a_rob = arob; alloc_a_value = aval;
        alloc_b_valid = bv; alloc_b_rob = brob; alloc_b_value = bval;
        alloc_uses_nzcv = un; alloc_nzcv_valid = nv; alloc_nzcv_rob = nrob; alloc_nzcv = nz;
    endtask

    task automatic set_cdb(input int k, input logic [ROB_IDX_W-1:0] rob, input logic [DATA_W-1:0] val,
                           input logic setn, input logic [3:0] nz);
        cdb_valid[k] = 1'b1;
        cdb_rob[k*ROB_IDX_W +: ROB_IDX_W] = rob;
        cdb_value[k*DATA_W +: DATA_W] = val;
        cdb_set_nzcv[k] = setn;
        cdb_nzcv[k*4 +: 4] = nz;
    endtask

    // Advance one edge, then drop one-shot inputs
    task automatic step();
        @(posedge clk_in);
        #1;
        alloc_valid = 1'b0;
        cdb_valid = '0;
        cdb_set_nzcv = '0;
        flush_in = 1'b0;
    endtask

    initial begin
        rst_in = 1'b1; flush_in = 1'b0; issue_ready = 1'b0;
        alloc_valid = 1'b0; alloc_op = '0; alloc_dst_rob = '0;
        alloc_a_valid = 1'b0; alloc_a_rob = '0; alloc_a_value = '0;
        alloc_b_valid = 1'b0; alloc_b_rob = '0; alloc_b_value = '0;
        alloc_uses_nzcv = 1'b0; alloc_nzcv_valid = 1'b0; alloc_nzcv_rob = '0; alloc_nzcv = '0;
        cdb_valid = '0; cdb_rob = '0; cdb_value = '0; cdb_set_nzcv = '0; cdb_nzcv = '0;
        repeat (3) @(posedge clk_in);
        #1;
        check("reset_occupancy", 64'(occupancy), 64'd0);
        check("reset_alloc_ready", 64'(alloc_ready), 64'd1);
        check("reset_issue_valid", 64'(issue_valid), 64'd0);
        check("reset_issue_data", issue_val_a | issue_val_b, 64'd0);
        rst_in = 1'b0;

        // Basic add: one-cycle latency, occupancy returns to zero
        issue_ready = 1'b1;
        set_alloc(FU_OP_PLUS, 6'd3, 1'b1, 6'd0, 64'd5, 1'b1, 6'd0, 64'd7, 1'b0, 1'b0, 6'd0, 4'd0);
        push_exp(FU_OP_PLUS, 64'd5, 64'd7, 6'd3, 4'd0);
        step();
        check("plus_issue_valid", 64'(issue_valid), 64'd1);
        check("plus_occ_1", 64'(occupancy), 64'd1);
        step();
        check("plus_occ_0", 64'(occupancy), 64'd0);

        // Back-to-back alloc and issue in the same cycle
        for (int i = 0; i < 3; i++) begin
            set_alloc(6'(2 + i), 6'(40 + i), 1'b1, 6'd0, 64'(100 + i), 1'b1, 6'd0, 64'(200 + i),
                      1'b0, 1'b0, 6'd0, 4'd0);
            push_exp(6'(2 + i), 64'(100 + i), 64'(200 + i), 6'(40 + i), 4'd0);
            step();
            check("stream_occ", 64'(occupancy), 64'd1);
        end
        step();
        check("stream_occ_drained", 64'(occupancy), 64'd0);

        // X waits on rob 9, younger Y is ready and goes first; port 1 then wakes X
        set_alloc(6'd10, 6'd10, 1'b0, 6'd9, 64'd0, 1'b1, 6'd0, 64'd1, 1'b0, 1'b0, 6'd0, 4'd0);
        step();
        check("x_waits", 64'(issue_valid), 64'd0);
        set_alloc(6'd11, 6'd11, 1'b1, 6'd0, 64'd2, 1'b1, 6'd0, 64'd3, 1'b0, 1'b0, 6'd0, 4'd0);
        push_exp(6'd11, 64'd2, 64'd3, 6'd11, 4'd0);
        step();
        step();
        set_cdb(0, 6'd20, 64'hDEAD, 1'b0, 4'd0);
        set_cdb(1, 6'd9, 64'h1234, 1'b0, 4'd0);
        push_exp(6'd10, 64'h1234, 64'd1, 6'd10, 4'd0);
        step();
        check("x_woken", 64'(issue_valid), 64'd1);
        step();
        check("xy_occ_0", 64'(occupancy), 64'd0);

        // Allocation bypass; both ports match, port 0 wins
        set_alloc(6'd4, 6'd12, 1'b0, 6'd4, 64'd0, 1'b1, 6'd0, 64'd6, 1'b0, 1'b0, 6'd0, 4'd0);
        set_cdb(0, 6'd4, 64'hAA, 1'b0, 4'd0);
        set_cdb(1, 6'd4, 64'hBB, 1'b0, 4'd0);
        push_exp(6'd4, 64'hAA, 64'd6, 6'd12, 4'd0);
        step();
        check("bypass_issue_valid", 64'(issue_valid), 64'd1);
        step();

        // Fill under backpressure, then drain in allocation order
        issue_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            set_alloc(6'(16 + i), 6'(20 + i), 1'b1, 6'd0, 64'(1000 + i), 1'b1, 6'd0, 64'(2000 + i),
                      1'b0, 1'b0, 6'd0, 4'd0);
            push_exp(6'(16 + i), 64'(1000 + i), 64'(2000 + i), 6'(20 + i), 4'd0);
            step();
        end
        check("full_occ", 64'(occupancy), 64'(DEPTH));
        check("full_alloc_ready", 64'(alloc_ready), 64'd0);
        check("full_oldest_dst", 64'(issue_dst_rob), 64'd20);
        set_alloc(6'd63, 6'd63, 1'b1, 6'd0, 64'd0, 1'b1, 6'd0, 64'd0, 1'b0, 1'b0, 6'd0, 4'd0);
        step();
        check("full_alloc_dropped", 64'(occupancy), 64'(DEPTH));
        issue_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 0)
                set_alloc(6'd63, 6'd63, 1'b1, 6'd0, 64'd0, 1'b1, 6'd0, 64'd0, 1'b0, 1'b0, 6'd0, 4'd0);
            step();
            check("drain_occ", 64'(occupancy), 64'(DEPTH - 1 - i));
        end

        // NZCV wake requires set_nzcv
        set_alloc(6'd5, 6'd13, 1'b1, 6'd0, 64'd1, 1'b1, 6'd0, 64'd2, 1'b1, 1'b0, 6'd2, 4'd0);
        step();
        set_cdb(0, 6'd2, 64'h55, 1'b0, 4'b1111);
        step();
        check("nzcv_still_waiting", 64'(issue_valid), 64'd0);
        set_cdb(1, 6'd2, 64'h66, 1'b1, 4'b0100);
        push_exp(6'd5, 64'd1, 64'd2, 6'd13, 4'b0100);
        step();
        check("nzcv_issue_valid", 64'(issue_valid), 64'd1);
        check("nzcv_value", 64'(issue_nzcv), 64'd4);
        step();

        // Flush with 5 entries held and a concurrent allocation
        issue_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_alloc(6'(30 + i), 6'(50 + i), 1'b1, 6'd0, 64'd9, 1'b1, 6'd0, 64'd9, 1'b0, 1'b0, 6'd0, 4'd0);
            step();
        end
        check("preflush_occ", 64'(occupancy), 64'd5);
        flush_in = 1'b1;
        issue_ready = 1'b1;
        set_alloc(6'd36, 6'd56, 1'b1, 6'd0, 64'd9, 1'b1, 6'd0, 64'd9, 1'b0, 1'b0, 6'd0, 4'd0);
        #1;
        check("flush_issue_valid", 64'(issue_valid), 64'd0);
        step();
        check("flush_occ", 64'(occupancy), 64'd0);
        step();
        check("flush_no_store", 64'(issue_valid), 64'd0);

        // Asynchronous reset mid-operation
        issue_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_alloc(6'(40 + i), 6'(60 + i), 1'b1, 6'd0, 64'd1, 1'b1, 6'd0, 64'd1, 1'b0, 1'b0, 6'd0, 4'd0);
            step();
        end
        check("prereset_occ", 64'(occupancy), 64'd2);
        #1 rst_in = 1'b1;
        #1;
        check("async_reset_occ", 64'(occupancy), 64'd0);
        check("async_reset_issue_valid", 64'(issue_valid), 64'd0);
        @(posedge clk_in);
        #1 rst_in = 1'b0;
        issue_ready = 1'b1;

        for (int n = 0; n < 20 && sb_q.size() > 0; n++) step();
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
